text_screen_composer: RTL and testbench

TEXT_SCREEN_COMPOSER -- requirements
Module: text_screen_composer

---
 rtl/text_screen_composer.sv | 192 +++++++++++++++++++
 tb/tb_text_screen_composer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_screen_composer.sv
// Text screen composer: rebuilds a ROWS x COLS character screen one cell per
// clock, laying out a coded-text block, a mode-dependent header and an
// optional decoded-text block, and serves registered reads of the screen.
//
// state | meaning
// IDLE  | waiting for start; screen holds the last rebuild
// COPY  | writing one cell per cycle in raster order
// DONE  | one-cycle completion pulse, then back to IDLE
module text_screen_composer #(
   parameter int  COLS       = 64,
   parameter int  CODED_ROWS = 4,
   parameter int  DEC_ROWS   = 4,
   localparam int ROWS       = 3 + CODED_ROWS + DEC_ROWS,
   localparam int RW         = $clog2(ROWS),
   localparam int CW         = $clog2(COLS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [1:0]                   mode,
   input  logic [2:0]                   key,
   input  logic                         init,
   input  logic [CODED_ROWS*COLS*8-1:0] src_coded,
   input  logic [DEC_ROWS*COLS*8-1:0]   src_plain,
   input  logic [RW-1:0]                rd_row,
   input  logic [CW-1:0]                rd_col,
   output logic [7:0]                   rd_char,
   output logic                         busy,
   output logic                         done,
   output logic                         fin
);

   typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

   // Strings are right-justified in a 36-byte field so one lookup serves all.
   localparam logic [287:0] STR_CODED = {152'h0, "Texto codificado:"};
   localparam logic [287:0] STR_NONE  = {136'h0, "Texto decodificado:"};
   localparam logic [287:0] STR_XOR   = "Texto decodificado con metodo XOR 0:";
   localparam logic [287:0] STR_NOT   = {16'h0, "Texto decodificado con metodo NOT:"};
   localparam logic [287:0] STR_ADD   = {16'h0, "Texto decodificado con metodo ADD:"};
   localparam int           XOR_KEY_POS = 34;

   function automatic logic [7:0] str_char(input logic [287:0] s, input int len, input int c);
      if (c < len) return s[8*(len-1-c) +: 8];
      return 8'h20;
   endfunction

   state_t        state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [1:0]    mode_lat_q, mode_lat_d;
   logic [2:0]    key_lat_q, key_lat_d;
   logic          fin_lat_q, fin_lat_d;
   logic          fin_q, fin_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [7:0]    rd_char_q, rd_char_d;
   logic [7:0]    screen_q [ROWS][COLS];
   logic [7:0]    screen_d [ROWS][COLS];
   logic [7:0]    wr_char;
   logic [7:0]    hdr_char;
   int            wr_r, wr_c;

   // FSM next state; mode/key freeze once a pass has latched fin.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      mode_lat_d = mode_lat_q;
      key_lat_d  = key_lat_q;
      fin_lat_d  = fin_lat_q;
      fin_d      = fin_q | init;
      busy_d     = busy_q;
      done_d     = done_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = COPY;
               row_d     = '0;
               col_d     = '0;
               fin_lat_d = fin_q;
               busy_d    = 1'b1;
               if (!fin_q) begin
                  mode_lat_d = mode;
                  key_lat_d  = key;
               end
            end
         end
         COPY: begin
            if (col_q == CW'(COLS-1)) begin
               col_d = '0;
               if (row_q == RW'(ROWS-1)) begin
                  state_d = DONE;
                  row_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // FSM and control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         mode_lat_q <= '0;
         key_lat_q  <= '0;
         fin_lat_q  <= 1'b0;
         fin_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         mode_lat_q <= mode_lat_d;
         key_lat_q  <= key_lat_d;
         fin_lat_q  <= fin_lat_d;
         fin_q      <= fin_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Character for the cell currently addressed by the copy counters.
   always_comb begin
      wr_r = int'(row_q);
      wr_c = int'(col_q);
      case (mode_lat_q)
         2'b00:   hdr_char = str_char(STR_NONE, 19, wr_c);
         2'b01:   hdr_char = (wr_c == XOR_KEY_POS) ? (8'h30 + {5'b0, key_lat_q})
                                                   : str_char(STR_XOR, 36, wr_c);
         2'b10:   hdr_char = str_char(STR_NOT, 34, wr_c);
         default: hdr_char = str_char(STR_ADD, 34, wr_c);
      endcase
      wr_char = 8'h20;
      if (wr_r == 0)
         wr_char = str_char(STR_CODED, 17, wr_c);
      else if (wr_r <= CODED_ROWS)
         wr_char = src_coded[8*((wr_r-1)*COLS + wr_c) +: 8];
      else if (wr_r == CODED_ROWS + 2)
         wr_char = hdr_char;
      else if (wr_r > CODED_ROWS + 2 && fin_lat_q)
         wr_char = src_plain[8*((wr_r-CODED_ROWS-3)*COLS + wr_c) +: 8];
   end

   // Screen next value: only the COPY state writes.
   always_comb begin
      screen_d = screen_q;
      if (state_q == COPY) screen_d[row_q][col_q] = wr_char;
   end

   // Screen storage, blanked by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               screen_q[r][c] <= 8'h20;
      end else begin
         screen_q <= screen_d;
      end
   end

   // Read lookup; out-of-range addresses read as blank.
   always_comb begin
      rd_char_d = 8'h20;
      if (int'(rd_row) < ROWS && int'(rd_col) < COLS) rd_char_d = screen_q[rd_row][rd_col];
   end

   // Registered read data (sees the pre-write value of a cell written this cycle).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_char_q <= 8'h20;
      else        rd_char_q <= rd_char_d;
   end

   assign rd_char = rd_char_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign fin     = fin_q;

endmodule

// File: tb/tb_text_screen_composer.sv
// Bench for text_screen_composer: default geometry plus a 40x8 instance.
module tb_text_screen_composer;

   localparam int COLS = 64, CR = 4, DR = 4;
   localparam int S_COLS = 40, S_CR = 2, S_DR = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   reset;
   logic                   start, init;
   logic [1:0]             mode;
   logic [2:0]             key;
   logic [CR*COLS*8-1:0]   src_coded;
   logic [DR*COLS*8-1:0]   src_plain;
   logic [3:0]             rd_row;
   logic [5:0]             rd_col;
   logic [7:0]             rd_char;
   logic                   busy, done, fin;

   logic                   s_start, s_init;
   logic [1:0]             s_mode;
   logic [2:0]             s_key;
   logic [S_CR*S_COLS*8-1:0] s_src_coded;
   logic [S_DR*S_COLS*8-1:0] s_src_plain;
   logic [2:0]             s_rd_row;
   logic [5:0]             s_rd_col;
   logic [7:0]             s_rd_char;
   logic                   s_busy, s_done, s_fin;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   text_screen_composer u_dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .key(key), .init(init),
      .src_coded(src_coded), .src_plain(src_plain), .rd_row(rd_row), .rd_col(rd_col),
      .rd_char(rd_char), .busy(busy), .done(done), .fin(fin)
   );

   text_screen_composer #(.COLS(S_COLS), .CODED_ROWS(S_CR), .DEC_ROWS(S_DR)) u_small (
      .clk(clk), .reset(reset), .start(s_start), .mode(s_mode), .key(s_key), .init(s_init),
      .src_coded(s_src_coded), .src_plain(s_src_plain), .rd_row(s_rd_row), .rd_col(s_rd_col),
      .rd_char(s_rd_char), .busy(s_busy), .done(s_done), .fin(s_fin)
   );

   function automatic logic [7:0] coded_ch(input int i, input int seed);
      return 8'h30 + 8'((i*3 + seed*11) % 64);
   endfunction

   function automatic logic [7:0] plain_ch(input int i, input int seed);
      return 8'h40 + 8'((i*5 + seed*13) % 60);
   endfunction

   function automatic string hdr_str(input int m, input int k);
      case (m)
         0:       return "Texto decodificado:";
         1:       return $sformatf("Texto decodificado con metodo XOR %0d:", k);
         2:       return "Texto decodificado con metodo NOT:";
         default: return "Texto decodificado con metodo ADD:";
      endcase
   endfunction

   function automatic logic [7:0] str_at(input string s, input int c);
      if (c < s.len()) return 8'(s[c]);
      return 8'h20;
   endfunction

   // Reference model of one screen cell.
   function automatic logic [7:0] exp_cell(input int r, input int c, input int cols,
                                           input int crows, input int drows, input int md,
                                           input int ky, input bit fn, input int clo,
                                           input int chi, input int sw, input int ps);
      int n;
      if (r >= 3 + crows + drows || c >= cols) return 8'h20;
      n = r*cols + c;
      if (r == 0) return str_at("Texto codificado:", c);
      if (r <= crows) return coded_ch((r-1)*cols + c, (n >= sw) ? chi : clo);
      if (r == crows + 1) return 8'h20;
      if (r == crows + 2) return str_at(hdr_str(md, ky), c);
      if (fn) return plain_ch((r-crows-3)*cols + c, ps);
      return 8'h20;
   endfunction

   task automatic fill_coded(input int s);
      for (int i = 0; i < CR*COLS; i++) src_coded[8*i +: 8] = coded_ch(i, s);
   endtask

   task automatic fill_plain(input int s);
      for (int i = 0; i < DR*COLS; i++) src_plain[8*i +: 8] = plain_ch(i, s);
   endtask

   task automatic fill_small(input int cs, input int ps);
      for (int i = 0; i < S_CR*S_COLS; i++) s_src_coded[8*i +: 8] = coded_ch(i, cs);
      for (int i = 0; i < S_DR*S_COLS; i++) s_src_plain[8*i +: 8] = plain_ch(i, ps);
   endtask

   // Runs one pass on the default instance; entered and left #1 after a rising edge.
   task automatic run_def(input int restart_k, input int chg_k, input int c_hi, input int rd_n,
                          output int done_k, output int pulses, output logic busy0,
                          output logic [7:0] old_v, output logic [7:0] new_v);
      int k;
      done_k = -1; pulses = 0; old_v = 8'h00; new_v = 8'h00;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy0 = busy;
      k = 0;
      while (k < 1000 && !(done_k >= 0 && k >= done_k + 3)) begin
         start = (k == restart_k - 1);
         if (k == chg_k) begin
            mode = mode ^ 2'b11;
            key  = key ^ 3'b111;
            fill_coded(c_hi);
         end
         if (rd_n >= 0 && k == rd_n) begin
            rd_row = 4'(rd_n / COLS);
            rd_col = 6'(rd_n % COLS);
         end
         @(posedge clk); k++; #1;
         if (done === 1'b1) begin
            pulses++;
            if (done_k < 0) done_k = k;
         end
         if (rd_n >= 0 && k == rd_n + 1) old_v = rd_char;
         if (rd_n >= 0 && k == rd_n + 2) new_v = rd_char;
      end
      start = 1'b0;
   endtask

   task automatic run_small(output int done_k, output int pulses);
      int k;
      done_k = -1; pulses = 0;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      k = 0;
      while (k < 1000 && !(done_k >= 0 && k >= done_k + 3)) begin
         @(posedge clk); k++; #1;
         if (s_done === 1'b1) begin
            pulses++;
            if (done_k < 0) done_k = k;
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] e;
      reset = 1'b0;
      start = 0; mode = 0; key = 0; init = 0; rd_row = 0; rd_col = 0;
      s_start = 0; s_mode = 0; s_key = 0; s_init = 0; s_rd_row = 0; s_rd_col = 0;
      fill_coded(0); fill_plain(1); fill_small(2, 5);
      repeat (3) @(posedge clk);
      #1;
      checks += 5;
      if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      if (fin !== 1'b0)       begin errors++; $display("FAIL reset_fin got %b exp 0", fin); end
      if (rd_char !== 8'h20)  begin errors++; $display("FAIL reset_rd_char got %h exp 20", rd_char); end
      if (s_busy !== 1'b0)    begin errors++; $display("FAIL reset_small_busy got %b exp 0", s_busy); end
      reset = 1'b1;
      @(posedge clk); #1;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < COLS; c++) begin
            rd_row = 4'(r); rd_col = 6'(c);
            exp_q.push_back(8'h20);
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (rd_char !== e) begin errors++; $display("FAIL blank_scan r%0d c%0d got %h exp %h", r, c, rd_char, e); end
         end
   endtask

   task automatic test_xor_pass();
      int dk, np; logic b0; logic [7:0] ov, nv, e;
      mode = 2'b01; key = 3'd5; init = 1'b0;
      run_def(-1, 50, 0, -1, dk, np, b0, ov, nv);
      checks += 4;
      if (b0 !== 1'b1) begin errors++; $display("FAIL xor_busy_e0 got %b exp 1", b0); end
      if (dk != 704)   begin errors++; $display("FAIL xor_done_edge got %0d exp 704", dk); end
      if (np != 1)     begin errors++; $display("FAIL xor_done_pulses got %0d exp 1", np); end
      if (fin !== 1'b0) begin errors++; $display("FAIL xor_fin got %b exp 0", fin); end
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < COLS; c++) begin
            rd_row = 4'(r); rd_col = 6'(c);
            exp_q.push_back(exp_cell(r, c, COLS, CR, DR, 1, 5, 0, 0, 0, 99999, 1));
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (rd_char !== e) begin errors++; $display("FAIL xor_scan r%0d c%0d got %h exp %h", r, c, rd_char, e); end
         end
   endtask

   task automatic test_init_freeze();
      int dk, np; logic b0; logic [7:0] ov, nv, e;
      init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      checks++;
      if (fin !== 1'b1) begin errors++; $display("FAIL init_fin_set got %b exp 1", fin); end
      mode = 2'b10; key = 3'd0;
      run_def(-1, -1, 0, -1, dk, np, b0, ov, nv);
      checks += 3;
      if (dk != 704)    begin errors++; $display("FAIL init_done_edge got %0d exp 704", dk); end
      if (np != 1)      begin errors++; $display("FAIL init_done_pulses got %0d exp 1", np); end
      if (fin !== 1'b1) begin errors++; $display("FAIL init_fin_sticky got %b exp 1", fin); end
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < COLS; c++) begin
            rd_row = 4'(r); rd_col = 6'(c);
            exp_q.push_back(exp_cell(r, c, COLS, CR, DR, 1, 5, 1, 0, 0, 99999, 1));
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (rd_char !== e) begin errors++; $display("FAIL freeze_scan r%0d c%0d got %h exp %h", r, c, rd_char, e); end
         end
   endtask

   task automatic test_back_to_back();
      int dk, np; logic b0; logic [7:0] ov, nv, e;
      fill_plain(4);
      run_def(100, -1, 0, -1, dk, np, b0, ov, nv);
      checks += 2;
      if (dk != 704) begin errors++; $display("FAIL b2b_done_edge got %0d exp 704", dk); end
      if (np != 1)   begin errors++; $display("FAIL b2b_done_pulses got %0d exp 1", np); end
      for (int r = 7; r < 11; r++)
         for (int c = 0; c < COLS; c++) begin
            rd_row = 4'(r); rd_col = 6'(c);
            exp_q.push_back(exp_cell(r, c, COLS, CR, DR, 1, 5, 1, 0, 0, 99999, 4));
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (rd_char !== e) begin errors++; $display("FAIL b2b_scan r%0d c%0d got %h exp %h", r, c, rd_char, e); end
         end
   endtask

   task automatic test_src_sampling();
      int dk, np; logic b0; logic [7:0] ov, nv, e;
      fill_coded(3);
      exp_q.push_back(coded_ch(1, 0));
      exp_q.push_back(coded_ch(1, 3));
      run_def(-1, 150, 7, 65, dk, np, b0, ov, nv);
      checks += 3;
      if (dk != 704) begin errors++; $display("FAIL sample_done_edge got %0d exp 704", dk); end
      e = exp_q.pop_front();
      if (ov !== e)  begin errors++; $display("FAIL rdw_old_value got %h exp %h", ov, e); end
      e = exp_q.pop_front();
      if (nv !== e)  begin errors++; $display("FAIL rdw_new_value got %h exp %h", nv, e); end
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < COLS; c++) begin
            rd_row = 4'(r); rd_col = 6'(c);
            exp_q.push_back(exp_cell(r, c, COLS, CR, DR, 1, 5, 1, 3, 7, 150, 4));
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (rd_char !== e) begin errors++; $display("FAIL sample_scan r%0d c%0d got %h exp %h", r, c, rd_char, e); end
         end
   endtask

   task automatic test_reset_mid();
      int k, np; logic [7:0] e;
      np = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (k < 299) begin
         @(posedge clk); k++; #1;
         if (done === 1'b1) np++;
      end
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      checks += 5;
      if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
      if (done !== 1'b0)     begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
      if (fin !== 1'b0)      begin errors++; $display("FAIL midrst_fin got %b exp 0", fin); end
      if (rd_char !== 8'h20) begin errors++; $display("FAIL midrst_rd_char got %h exp 20", rd_char); end
      if (np != 0)           begin errors++; $display("FAIL midrst_done_pulses got %0d exp 0", np); end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < COLS; c++) begin
            rd_row = 4'(r); rd_col = 6'(c);
            exp_q.push_back(8'h20);
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (rd_char !== e) begin errors++; $display("FAIL midrst_scan r%0d c%0d got %h exp %h", r, c, rd_char, e); end
         end
   endtask

   task automatic test_mode_none();
      int dk, np; logic b0; logic [7:0] ov, nv, e;
      mode = 2'b00; key = 3'd6;
      run_def(-1, -1, 0, -1, dk, np, b0, ov, nv);
      checks++;
      if (dk != 704) begin errors++; $display("FAIL none_done_edge got %0d exp 704", dk); end
      for (int r = 6; r < 8; r++)
         for (int c = 0; c < COLS; c++) begin
            rd_row = 4'(r); rd_col = 6'(c);
            exp_q.push_back(exp_cell(r, c, COLS, CR, DR, 0, 6, 0, 3, 3, 99999, 4));
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (rd_char !== e) begin errors++; $display("FAIL none_scan r%0d c%0d got %h exp %h", r, c, rd_char, e); end
         end
   endtask

   task automatic test_small();
      int dk, np; logic [7:0] e;
      s_mode = 2'b01; s_key = 3'd7; s_init = 1'b0;
      fill_small(2, 5);
      run_small(dk, np);
      checks += 2;
      if (dk != 320) begin errors++; $display("FAIL small_done_edge got %0d exp 320", dk); end
      if (np != 1)   begin errors++; $display("FAIL small_done_pulses got %0d exp 1", np); end
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 64; c++) begin
            s_rd_row = 3'(r); s_rd_col = 6'(c);
            exp_q.push_back(exp_cell(r, c, S_COLS, S_CR, S_DR, 1, 7, 0, 2, 2, 99999, 5));
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (s_rd_char !== e) begin errors++; $display("FAIL small_scan r%0d c%0d got %h exp %h", r, c, s_rd_char, e); end
         end
      s_mode = 2'b11;
      run_small(dk, np);
      checks++;
      if (dk != 320) begin errors++; $display("FAIL small_add_done_edge got %0d exp 320", dk); end
      for (int c = 0; c < 64; c++) begin
         s_rd_row = 3'd4; s_rd_col = 6'(c);
         exp_q.push_back(exp_cell(4, c, S_COLS, S_CR, S_DR, 3, 7, 0, 2, 2, 99999, 5));
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if (s_rd_char !== e) begin errors++; $display("FAIL small_add_hdr c%0d got %h exp %h", c, s_rd_char, e); end
      end
   endtask

   initial begin
      test_reset();
      test_xor_pass();
      test_init_freeze();
      test_back_to_back();
      test_src_sampling();
      test_reset_mid();
      test_mode_none();
      test_small();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
